// File: rtl/video_timing_pkg.sv
// video_timing_pkg: 720p60 timing defaults, line/frame totals and FSM encoding shared by the video path
package video_timing_pkg;

  localparam int CNT_W = 12;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;

  // Total period of one axis: active + front porch + sync + back porch.
  function automatic int span(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = span(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = span(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing, FIFO pixel fetch and 3-stage aligned sync/DE/RGB output for the HDMI encoder
module vga_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [23:0] pix_data,
  output logic        pix_req,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic [23:0] rgb_data,
  output logic        underflow
);

  localparam int H_TOTAL = span(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] HA  = 12'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS0 = 12'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] HL  = 12'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VA  = 12'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS0 = 12'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS1 = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] VL  = 12'(V_TOTAL - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             run, h_last, v_last, active, hs_on, vs_on;
  logic             hs1, vs1, de2, emp2, hs2, vs2;

  // Position decode: everything below is derived from the registered counters.
  always_comb begin
    run         = state == ST_RUN;
    h_last      = h_cnt == HL;
    v_last      = v_cnt == VL;
    frame_start = run && h_cnt == '0 && v_cnt == '0;
    active      = run && h_cnt < HA && v_cnt < VA;
    hs_on       = run && h_cnt >= HS0 && h_cnt < HS1;
    vs_on       = run && v_cnt >= VS0 && v_cnt < VS1;
  end

  // FSM and raster counters; a started frame always runs to its last back-porch clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      state <= enable ? ST_RUN : ST_IDLE;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 12'd1;
      v_cnt <= !h_last ? v_cnt : v_last ? '0 : v_cnt + 12'd1;
      if (h_last && v_last && !enable) state <= ST_IDLE;
    end
  end

  // Alignment pipeline: req -> FIFO data/empty capture -> output, syncs delayed to match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_req   <= 1'b0;
      hs1       <= ~SYNC_POL;
      vs1       <= ~SYNC_POL;
      de2       <= 1'b0;
      emp2      <= 1'b0;
      hs2       <= ~SYNC_POL;
      vs2       <= ~SYNC_POL;
      rgb_valid <= 1'b0;
      rgb_data  <= '0;
      hsync     <= ~SYNC_POL;
      vsync     <= ~SYNC_POL;
      underflow <= 1'b0;
    end else begin
      pix_req   <= active;
      hs1       <= hs_on ? SYNC_POL : ~SYNC_POL;
      vs1       <= vs_on ? SYNC_POL : ~SYNC_POL;
      de2       <= pix_req;
      emp2      <= pix_req && fifo_empty;
      hs2       <= hs1;
      vs2       <= vs1;
      rgb_valid <= de2;
      rgb_data  <= de2 && !emp2 ? pix_data : '0;
      hsync     <= hs2;
      vsync     <= vs2;
      underflow <= (pix_req && fifo_empty) || (underflow && !frame_start);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a reduced-size raster (17x11) with both sync polarities
module tb_vga_timing_gen;
  import video_timing_pkg::*;

  localparam int HA = 8, HF = 2, HS = 3, HB = 4;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;

  logic        clk = 1'b0;
  logic        rst_n, enable, fifo_empty;
  logic [23:0] pix_data = '0;
  logic        pix_req, frame_start, hsync, vsync, rgb_valid, underflow;
  logic [23:0] rgb_data;
  logic        n_pix_req, n_frame_start, n_hsync, n_vsync, n_rgb_valid, n_underflow;
  logic [23:0] n_rgb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty), .pix_data(pix_data),
    .pix_req(pix_req), .frame_start(frame_start), .hsync(hsync), .vsync(vsync),
    .rgb_valid(rgb_valid), .rgb_data(rgb_data), .underflow(underflow)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) u_neg (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty), .pix_data(pix_data),
    .pix_req(n_pix_req), .frame_start(n_frame_start), .hsync(n_hsync), .vsync(n_vsync),
    .rgb_valid(n_rgb_valid), .rgb_data(n_rgb_data), .underflow(n_underflow)
  );

  // FIFO model: registered read, incrementing words, no pop while empty.
  logic [23:0] word = 24'h100000;
  always @(posedge clk)
    if (pix_req && !fifo_empty) begin
      pix_data <= word;
      word     <= word + 24'd1;
    end

  // Monitor: running totals and measured sync shapes, sampled on the falling edge.
  int cyc = 0, rv_total = 0, blk_total = 0, pix_bad = 0, neg_bad = 0;
  int hs_rise = 0, hs_period = 0, hs_run = 0, hs_len = 0, vs_run = 0, vs_len = 0;
  logic hs_prev = 1'b0, vs_prev = 1'b0, hs_seen = 1'b0, sync_ok = 1'b1;
  logic [23:0] exp_w = 24'h100000;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) sync_ok = 1'b0;
    if (rgb_valid) rv_total++;
    if (rgb_valid && rgb_data == 24'h0) blk_total++;
    if (rgb_valid && rgb_data != 24'h0) begin
      if (sync_ok && rgb_data !== exp_w) pix_bad++;
      exp_w   = rgb_data + 24'd1;
      sync_ok = 1'b1;
    end
    if (n_hsync !== ~hsync || n_vsync !== ~vsync || n_rgb_valid !== rgb_valid ||
        n_rgb_data !== rgb_data || n_pix_req !== pix_req || n_frame_start !== frame_start ||
        n_underflow !== underflow) neg_bad++;
    if (hsync && !hs_prev) begin
      if (hs_seen) hs_period = cyc - hs_rise;
      hs_rise = cyc;
      hs_seen = 1'b1;
    end
    if (hsync) hs_run++;
    else if (hs_prev) begin hs_len = hs_run; hs_run = 0; end
    if (vsync) vs_run++;
    else if (vs_prev) begin vs_len = vs_run; vs_run = 0; end
    hs_prev = hsync;
    vs_prev = vsync;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int rv0;

  initial begin
    rst_n = 1'b0; enable = 1'b0; fifo_empty = 1'b0;
    tick(3);
    chk("rst_pix_req", pix_req, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_rgb_valid", rgb_valid, 0);
    chk("rst_rgb_data", rgb_data, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_hsync", hsync, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_neg_hsync", n_hsync, 1);
    chk("rst_neg_vsync", n_vsync, 1);
    chk("rst_h_cnt", u_dut.h_cnt, 0);
    chk("rst_v_cnt", u_dut.v_cnt, 0);
    rst_n = 1'b1;
    tick(4);
    chk("idle_frame_start", frame_start, 0);
    chk("idle_pix_req", pix_req, 0);
    chk("idle_neg_hsync", n_hsync, 1);
    chk("idle_h_cnt", u_dut.h_cnt, 0);
    enable = 1'b1;
    tick(1);                                   // t=0
    chk("f1_frame_start", frame_start, 1);
    chk("f1_h0", u_dut.h_cnt, 0);
    chk("f1_v0", u_dut.v_cnt, 0);
    rv0 = rv_total;
    tick(1);                                   // t=1
    chk("f1_pix_req", pix_req, 1);
    chk("f1_fs_single", frame_start, 0);
    chk("f1_valid_lag", rgb_valid, 0);
    tick(2);                                   // t=3
    chk("first_valid", rgb_valid, 1);
    chk("first_word", rgb_data, 32'h100000);
    tick(7);                                   // t=10
    chk("last_of_line0", rgb_data, 32'h100007);
    tick(1);                                   // t=11
    chk("line0_valid_end", rgb_valid, 0);
    chk("blank_data", rgb_data, 0);
    tick(1);                                   // t=12
    chk("hsync_before", hsync, 0);
    tick(1);                                   // t=13
    chk("hsync_on", hsync, 1);
    chk("neg_hsync_on", n_hsync, 0);
    tick(3);                                   // t=16
    chk("hsync_off", hsync, 0);
    tick(105);                                 // t=121
    chk("vsync_before", vsync, 0);
    tick(1);                                   // t=122
    chk("vsync_on", vsync, 1);
    chk("neg_vsync_on", n_vsync, 0);
    tick(65);                                  // t=187
    chk("f2_frame_start", frame_start, 1);
    chk("f1_valid_count", rv_total - rv0, HA * VA);
    chk("hsync_period", hs_period, 17);
    chk("hsync_width", hs_len, HS);
    chk("vsync_width", vs_len, VS * 17);
    tick(54);                                  // t=241: pixel (2,3) of frame 2 requested
    chk("uf_pix_req", pix_req, 1);
    chk("uf_before", underflow, 0);
    fifo_empty = 1'b1;
    tick(1);                                   // t=242
    chk("uf_set", underflow, 1);
    tick(1);                                   // t=243
    chk("black0_valid", rgb_valid, 1);
    chk("black0", rgb_data, 0);
    tick(1);                                   // t=244
    chk("black1", rgb_data, 0);
    fifo_empty = 1'b0;
    tick(1);                                   // t=245
    chk("black2", rgb_data, 0);
    tick(1);                                   // t=246
    chk("after_black", rgb_data, 32'h10004A);
    tick(127);                                 // t=373
    chk("uf_sticky", underflow, 1);
    tick(1);                                   // t=374
    chk("f3_frame_start", frame_start, 1);
    chk("uf_until_fs", underflow, 1);
    chk("f12_valid_count", rv_total - rv0, 2 * HA * VA);
    rv0 = rv_total;
    tick(1);                                   // t=375
    chk("uf_cleared", underflow, 0);
    tick(50);                                  // t=425: line 3 of frame 3
    enable = 1'b0;
    tick(135);                                 // t=560
    chk("drop_last_h", u_dut.h_cnt, 16);
    chk("drop_last_v", u_dut.v_cnt, 10);
    chk("drop_still_run", u_dut.state, ST_RUN);
    tick(1);                                   // t=561
    chk("drop_idle", u_dut.state, ST_IDLE);
    chk("drop_no_fs", frame_start, 0);
    chk("drop_h0", u_dut.h_cnt, 0);
    tick(4);                                   // t=565
    chk("f3_valid_count", rv_total - rv0, HA * VA);
    tick(5);                                   // t=570
    chk("idle2_pix_req", pix_req, 0);
    chk("idle2_valid", rgb_valid, 0);
    chk("idle2_data", rgb_data, 0);
    chk("idle2_hsync", hsync, 0);
    chk("idle2_vsync", vsync, 0);
    chk("idle2_neg_hsync", n_hsync, 1);
    enable = 1'b1;
    tick(1);                                   // t=571
    chk("reen_fs", frame_start, 1);
    chk("reen_pix_req", pix_req, 0);
    tick(1);                                   // t=572
    chk("reen_pix_req_on", pix_req, 1);
    tick(38);                                  // t=610: line 2, h=5
    chk("midline_valid", rgb_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_pix_req", pix_req, 0);
    chk("arst_valid", rgb_valid, 0);
    chk("arst_data", rgb_data, 0);
    chk("arst_h_cnt", u_dut.h_cnt, 0);
    chk("arst_v_cnt", u_dut.v_cnt, 0);
    chk("arst_state", u_dut.state, ST_IDLE);
    chk("arst_neg_hsync", n_hsync, 1);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("restart_fs", frame_start, 1);
    chk("restart_h0", u_dut.h_cnt, 0);
    tick(190);
    chk("black_total", blk_total, 3);
    chk("pixel_order", pix_bad, 0);
    chk("neg_polarity", neg_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
